intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter GRN_A_MIN, default 8: minimum main-road green, in cycles.
REQ-002 SHALL have parameter YLW_TIME, default 3: yellow duration for either road, in cycles.
REQ-003 SHALL have parameter ALL_RED_TIME, default 1: all-red clearance duration, in cycles.
REQ-004 SHALL have parameter GRN_B_MIN, default 4: minimum side-road green, in cycles.
REQ-005 SHALL have parameter GRN_B_MAX, default 12: maximum side-road green, in cycles.
REQ-006 SHALL have parameter WALK_TIME, default 6: minimum side-road green when a walk phase is active, in cycles.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with ports named Clock and Reset.
REQ-008 SHALL have these ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- CAR_B  in  1  side-road vehicle sensor, level-sensitive.
- PED  in  1  pedestrian request, pulse or level.
- redA, ylwA, grnA  out  1 each  main-road lamps.
- redB, ylwB, grnB  out  1 each  side-road lamps.
- walk  out  1  pedestrian walk lamp.
REQ-009 SHALL treat parameter values as legal only when all are >=1, GRN_B_MIN<=GRN_B_MAX and WALK_TIME<=GRN_B_MAX; other values are unsupported.

Function
REQ-010 SHALL implement a Moore FSM with states A_GRN, A_YLW, RED_AB, B_GRN, B_YLW and RED_BA.
REQ-011 SHALL decode outputs combinationally from the registered state only, so lamps change in the cycle after the transition edge.
REQ-012 SHALL drive lamps per state:
- A_GRN: grnA and redB.
- A_YLW: ylwA and redB.
- RED_AB and RED_BA: redA and redB.
- B_GRN: redA and grnB.
- B_YLW: redA and ylwB.
REQ-013 SHALL assert exactly one lamp per road in every cycle.
REQ-014 SHALL keep an up-counter cnt that is cleared on every state change and incremented otherwise; cnt width is sized for GRN_B_MAX.
REQ-015 SHALL take A_GRN->A_YLW when cnt>=GRN_A_MIN-1 and (CAR_B or ped_pending); A_GRN otherwise holds indefinitely.
REQ-016 SHALL take A_YLW->RED_AB and B_YLW->RED_BA when cnt==YLW_TIME-1.
REQ-017 SHALL take RED_AB->B_GRN and RED_BA->A_GRN when cnt==ALL_RED_TIME-1.
REQ-018 SHALL take B_GRN->B_YLW when cnt==GRN_B_MAX-1, or when cnt>=min_b-1 and !CAR_B; min_b is WALK_TIME if walk_active, else GRN_B_MIN.
REQ-019 SHALL let GRN_B_MAX take priority over CAR_B in B_GRN: the side road never starves the main road.
REQ-020 SHALL never enter a green state from a non-red state.

Reset
REQ-021 SHALL, when Reset is high at a clock edge, set state=A_GRN, cnt=0, ped_pending=0 and walk_active=0, regardless of the current state.
REQ-022 SHALL therefore drive grnA=1, redB=1 and all other outputs 0 in the first cycle after reset.
REQ-023 SHALL give Reset priority over every input and every transition.

Configuration
REQ-024 SHALL, with macro INTERSECTION_PED_EN defined, support the pedestrian phase:
- ped_pending is set by PED and cleared on entry to B_GRN.
- PED high on the entry edge leaves ped_pending set, so set wins.
- walk_active is loaded from ped_pending on entry to B_GRN and cleared on leaving B_GRN.
- walk = walk_active in B_GRN, and 0 elsewhere.
REQ-025 SHALL, with INTERSECTION_PED_EN undefined, ignore PED, tie walk=0, hold ped_pending=walk_active=0, and use min_b=GRN_B_MIN.

Structure
REQ-026 SHALL place the state typedef/encoding (localparams A_GRN..RED_BA, 3 bits) and the counter width function in shared package intersection_pkg.
REQ-027 SHALL isolate cnt in one sub-module, phase_timer, with ports Clock, Reset, clr and cnt.
REQ-028 SHALL keep the FSM and output decode in intersection_ctrl.

Verification
REQ-029 SHALL cover: Reset, then CAR_B=1 held -> grnA 8 cycles, ylwA 3, all-red 1, grnB 12, ylwB 3, all-red 1, then grnA again.
REQ-030 SHALL cover: CAR_B=0 and PED=0 for 100 cycles -> grnA and redB constant, walk=0.
REQ-031 SHALL cover: CAR_B pulse of 1 cycle at cycle 20 -> A_YLW from cycle 21, and grnB lasting exactly 4 cycles.
REQ-032 SHALL cover, with INTERSECTION_PED_EN: PED 1-cycle pulse at cycle 10, CAR_B=0 -> walk=1 throughout B_GRN, which lasts 6 cycles; a second PED during that B_GRN -> another B phase follows.
REQ-033 SHALL cover: Reset asserted for 1 cycle mid-B_GRN -> next cycle grnA=1, redB=1, walk=0, and A_GRN lasts at least 8 cycles.
REQ-034 SHALL cover, without INTERSECTION_PED_EN: PED held high, CAR_B=0 -> no phase change, walk=0.
REQ-035 SHALL check, on every bench cycle, that exactly one lamp per road is on and that grnA and grnB are never both 1.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection controller: phase encoding and
// the phase-timer width helper.
package intersection_pkg;

    // Six-phase signal cycle, 3-bit encoding.
    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YLW  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YLW  = 3'd4,
        RED_BA = 3'd5
    } state_t;

    // Bits needed to hold counts up to and including max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, cleared on change.
module phase_timer
    import intersection_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear on phase change, otherwise count up. Saturates so an
    // indefinitely held main-road green can never wrap back below its minimum.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection controller: Moore FSM with lamp decode.
// Optional pedestrian walk phase enabled by defining INTERSECTION_PED_EN.
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned GRN_A_MIN    = 8,
    parameter int unsigned YLW_TIME     = 3,
    parameter int unsigned ALL_RED_TIME = 1,
    parameter int unsigned GRN_B_MIN    = 4,
    parameter int unsigned GRN_B_MAX    = 12,
    parameter int unsigned WALK_TIME    = 6
) (
    input  logic Clock,
    input  logic Reset,
    input  logic CAR_B,
    input  logic PED,
    output logic redA,
    output logic ylwA,
    output logic grnA,
    output logic redB,
    output logic ylwB,
    output logic grnB,
    output logic walk
);

    localparam int unsigned MAX_AB = (GRN_A_MIN > GRN_B_MAX) ? GRN_A_MIN : GRN_B_MAX;
    localparam int unsigned MAX_YR = (YLW_TIME > ALL_RED_TIME) ? YLW_TIME : ALL_RED_TIME;
    localparam int unsigned CW     = cnt_width((MAX_AB > MAX_YR) ? MAX_AB : MAX_YR);

    localparam logic [CW-1:0] A_MIN_M1 = CW'(GRN_A_MIN - 1);
    localparam logic [CW-1:0] YLW_M1   = CW'(YLW_TIME - 1);
    localparam logic [CW-1:0] AR_M1    = CW'(ALL_RED_TIME - 1);
    localparam logic [CW-1:0] B_MIN_M1 = CW'(GRN_B_MIN - 1);
    localparam logic [CW-1:0] B_MAX_M1 = CW'(GRN_B_MAX - 1);
    localparam logic [CW-1:0] WALK_M1  = CW'(WALK_TIME - 1);

    state_t        state_q, state_d;
    logic          ped_pending_q, ped_pending_d;
    logic          walk_active_q, walk_active_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] min_b_m1;
    logic          clr;
    logic          entering_b;
    logic          leaving_b;

    phase_timer #(.W(CW)) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (clr),
        .cnt   (cnt)
    );

    // Next-state logic; timer clears whenever the phase is about to change.
    always_comb begin
        state_d  = state_q;
        min_b_m1 = walk_active_q ? WALK_M1 : B_MIN_M1;
        case (state_q)
            A_GRN:   if (cnt >= A_MIN_M1 && (CAR_B || ped_pending_q)) state_d = A_YLW;
            A_YLW:   if (cnt == YLW_M1) state_d = RED_AB;
            RED_AB:  if (cnt == AR_M1) state_d = B_GRN;
            B_GRN:   if (cnt == B_MAX_M1 || (cnt >= min_b_m1 && !CAR_B)) state_d = B_YLW;
            B_YLW:   if (cnt == YLW_M1) state_d = RED_BA;
            RED_BA:  if (cnt == AR_M1) state_d = A_GRN;
            default: state_d = A_GRN;
        endcase
        clr        = (state_d != state_q);
        entering_b = (state_q == RED_AB) && (state_d == B_GRN);
        leaving_b  = (state_q == B_GRN) && (state_d != B_GRN);
    end

`ifdef INTERSECTION_PED_EN
    // Pedestrian bookkeeping: a request on the entry edge stays pending
    // (set wins); walk is latched for the side-road green it enters.
    always_comb begin
        ped_pending_d = ped_pending_q;
        walk_active_d = walk_active_q;
        if (entering_b) begin
            ped_pending_d = 1'b0;
            walk_active_d = ped_pending_q;
        end else if (leaving_b) begin
            walk_active_d = 1'b0;
        end
        if (PED) begin
            ped_pending_d = 1'b1;
        end
    end
`else
    logic ped_unused;
    assign ped_unused = PED ^ entering_b ^ leaving_b;

    // Pedestrian phase disabled: no pending requests, no walk.
    always_comb begin
        ped_pending_d = 1'b0;
        walk_active_d = 1'b0;
    end
`endif

    // State and pedestrian registers; reset overrides everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= A_GRN;
            ped_pending_q <= 1'b0;
            walk_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_active_q <= walk_active_d;
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        redA = 1'b0;
        ylwA = 1'b0;
        grnA = 1'b0;
        redB = 1'b0;
        ylwB = 1'b0;
        grnB = 1'b0;
        walk = 1'b0;
        case (state_q)
            A_GRN:  begin grnA = 1'b1; redB = 1'b1; end
            A_YLW:  begin ylwA = 1'b1; redB = 1'b1; end
            B_GRN:  begin redA = 1'b1; grnB = 1'b1; walk = walk_active_q; end
            B_YLW:  begin redA = 1'b1; ylwB = 1'b1; end
            default: begin redA = 1'b1; redB = 1'b1; end
        endcase
    end

endmodule
